shift_add_multiplier: RTL

- Sequential 8x8 unsigned multiplier for the ALU datapath.
- Sits directly upstream of the ALU result mux. Drives an 8-bit ripple adder with the partial-product accumulator and multiplicand, then consumes its sum and carry-out.
- Produces a 16-bit product after a fixed number of cycles, using a start/busy/done handshake.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/addition.sv | 23 ++
 rtl/shift_add_multiplier.sv | 115 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM states, default width and
// the helper that sizes the iteration counter.
package alu_pkg;

    localparam int MUL_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Counter must hold values 0..w-1 with one spare bit of headroom.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_width(MUL_WIDTH);

endpackage

// File: rtl/addition.sv
// Combinational ripple-carry adder: Z = X + Y, carry-out on cout.
module addition #(
    parameter int WIDTH = 8
) (
    output logic [WIDTH-1:0] Z,
    output logic             cout,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y
);

    // Ripple the carry bit by bit from LSB to MSB.
    always_comb begin
        logic carry;
        carry = 1'b0;
        Z     = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            Z[i]  = X[i] ^ Y[i] ^ carry;
            carry = (X[i] & Y[i]) | (carry & (X[i] ^ Y[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier with start/busy/done
// handshake. One add-and-shift iteration per cycle, WIDTH iterations,
// product registered and held until the next accepted start.
module shift_add_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = cnt_width(WIDTH);

    mul_state_t             r_state;
    logic [WIDTH-1:0]       r_acc_hi;
    logic [WIDTH-1:0]       r_q;
    logic [WIDTH-1:0]       r_m;
    logic [CW-1:0]          r_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic [2*WIDTH-1:0]     r_product;

    logic [WIDTH-1:0]       w_y;
    logic [WIDTH-1:0]       w_sum;
    logic                   w_cout;
    logic                   w_last;
    logic [2*WIDTH-1:0]     w_next_pair;

    // Select the addend: multiplicand when the current multiplier LSB is set.
    always_comb begin
        w_y = {WIDTH{1'b0}};
        if (r_q[0]) begin
            w_y = r_m;
        end else begin
            w_y = {WIDTH{1'b0}};
        end
    end

    addition #(.WIDTH(WIDTH)) u_add (
        .Z    (w_sum),
        .cout (w_cout),
        .X    (r_acc_hi),
        .Y    (w_y)
    );

    // Right-shift of {cout,sum,q}: carry lands in the accumulator MSB.
    always_comb begin
        w_next_pair = {w_cout, w_sum, r_q[WIDTH-1:1]};
        w_last      = (r_cnt == CW'(WIDTH - 1));
    end

    // Control FSM plus datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc_hi  <= {WIDTH{1'b0}};
            r_q       <= {WIDTH{1'b0}};
            r_m       <= {WIDTH{1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= {(2*WIDTH){1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_m      <= a;
                        r_q      <= b;
                        r_acc_hi <= {WIDTH{1'b0}};
                        r_cnt    <= {CW{1'b0}};
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                RUN: begin
                    {r_acc_hi, r_q} <= w_next_pair;
                    r_cnt           <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_product <= w_next_pair;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_state   <= RUN;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule
